// File: rtl/qspi_xip_pkg.sv
// Shared definitions for the QSPI XIP subsystem: fill FSM encoding,
// default geometry of a flash line and the quad-I/O read command.
package qspi_xip_pkg;

    localparam int LINE_SIZE_DEF = 128;
    localparam int ADDR_W_DEF    = 24;
    localparam int CNT_W_DEF     = 16;

    // A 128-bit line spans 16 bytes, so the low 4 address bits select a byte within it.
    localparam int LINE_OFS_W = 4;

    localparam logic [7:0] QSPI_CMD_QUAD_IO_READ = 8'hEB;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } fill_state_e;

    function automatic logic [ADDR_W_DEF-1:0] line_base(input logic [ADDR_W_DEF-LINE_OFS_W-1:0] line_idx);
        return {line_idx, {LINE_OFS_W{1'b0}}};
    endfunction

endpackage

// File: rtl/qspi_req_slot.sv
// One requester's latched fill request: holds the pending flag and the
// line index until the arbiter clears it after the response.
module qspi_req_slot
    import qspi_xip_pkg::*;
#(
    parameter int PADDR_W = ADDR_W_DEF - LINE_OFS_W
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic               req,
    input  logic [PADDR_W-1:0] line_addr,
    input  logic               clr,
    output logic               ready,
    output logic               pend,
    output logic [PADDR_W-1:0] paddr
);

    logic               pend_q;
    logic               pend_d;
    logic [PADDR_W-1:0] paddr_q;
    logic [PADDR_W-1:0] paddr_d;

    // clr only arrives while pend is set, so it can never collide with an acceptance.
    always_comb begin
        pend_d  = pend_q;
        paddr_d = paddr_q;
        if (clr) begin
            pend_d = 1'b0;
        end else if (req && !pend_q) begin
            pend_d  = 1'b1;
            paddr_d = line_addr;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend_q  <= 1'b0;
            paddr_q <= '0;
        end else begin
            pend_q  <= pend_d;
            paddr_q <= paddr_d;
        end
    end

    assign ready = ~pend_q;
    assign pend  = pend_q;
    assign paddr = paddr_q;

endmodule

// File: rtl/qspi_fill_arbiter.sv
// Round-robin arbiter sharing one QSPI line reader between the I-side and
// D-side caches, merging same-line requests into a single flash read.
module qspi_fill_arbiter
    import qspi_xip_pkg::*;
#(
    parameter int LINE_SIZE = LINE_SIZE_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic                 req0,
    input  logic [ADDR_W-1:0]    addr0,
    output logic                 ready0,
    output logic                 rsp_valid0,
    input  logic                 req1,
    input  logic [ADDR_W-1:0]    addr1,
    output logic                 ready1,
    output logic                 rsp_valid1,
    output logic [LINE_SIZE-1:0] rsp_line,
    output logic                 fr_rd,
    output logic [ADDR_W-1:0]    fr_addr,
    input  logic                 fr_done,
    input  logic [LINE_SIZE-1:0] fr_line,
    output logic                 busy,
    output logic [CNT_W-1:0]     fill_count
);

    localparam int PADDR_W = ADDR_W - LINE_OFS_W;

    logic               pend0;
    logic               pend1;
    logic [PADDR_W-1:0] paddr0;
    logic [PADDR_W-1:0] paddr1;
    logic               clr0;
    logic               clr1;
    logic               unused_addr_bits;

    fill_state_e          state_q, state_d;
    logic                 gnt_q, gnt_d;
    logic                 merge_q, merge_d;
    logic                 last_grant_q, last_grant_d;
    logic [ADDR_W-1:0]    fr_addr_q, fr_addr_d;
    logic [LINE_SIZE-1:0] rsp_line_q, rsp_line_d;
    logic [CNT_W-1:0]     fill_count_q, fill_count_d;

    qspi_req_slot #(.PADDR_W(PADDR_W)) u_slot0 (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .req       (req0),
        .line_addr (addr0[ADDR_W-1:LINE_OFS_W]),
        .clr       (clr0),
        .ready     (ready0),
        .pend      (pend0),
        .paddr     (paddr0)
    );

    qspi_req_slot #(.PADDR_W(PADDR_W)) u_slot1 (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .req       (req1),
        .line_addr (addr1[ADDR_W-1:LINE_OFS_W]),
        .clr       (clr1),
        .ready     (ready1),
        .pend      (pend1),
        .paddr     (paddr1)
    );

    // Byte offsets within a line never influence arbitration or the issued address.
    assign unused_addr_bits = ^{addr0[LINE_OFS_W-1:0], addr1[LINE_OFS_W-1:0]};

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        merge_d      = merge_q;
        last_grant_d = last_grant_q;
        fr_addr_d    = fr_addr_q;
        rsp_line_d   = rsp_line_q;
        fill_count_d = fill_count_q;
        clr0         = 1'b0;
        clr1         = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pend0 || pend1) begin
                    // On a tie the port that did not win last time goes first.
                    gnt_d     = (pend0 && pend1) ? ~last_grant_q : pend1;
                    merge_d   = pend0 && pend1 && (paddr0 == paddr1);
                    fr_addr_d = {(gnt_d ? paddr1 : paddr0), {LINE_OFS_W{1'b0}}};
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                state_d = BUSY;
            end
            BUSY: begin
                if (fr_done) begin
                    rsp_line_d = fr_line;
                    if (fill_count_q != {CNT_W{1'b1}}) begin
                        fill_count_d = fill_count_q + CNT_W'(1);
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                clr0         = ~gnt_q | merge_q;
                clr1         = gnt_q | merge_q;
                last_grant_d = gnt_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= IDLE;
            gnt_q        <= 1'b0;
            merge_q      <= 1'b0;
            last_grant_q <= 1'b1;
            fr_addr_q    <= '0;
            rsp_line_q   <= '0;
            fill_count_q <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            merge_q      <= merge_d;
            last_grant_q <= last_grant_d;
            fr_addr_q    <= fr_addr_d;
            rsp_line_q   <= rsp_line_d;
            fill_count_q <= fill_count_d;
        end
    end

    assign fr_rd      = (state_q == ISSUE);
    assign busy       = (state_q != IDLE);
    assign rsp_valid0 = (state_q == RESP) && (~gnt_q | merge_q);
    assign rsp_valid1 = (state_q == RESP) && (gnt_q | merge_q);
    assign fr_addr    = fr_addr_q;
    assign rsp_line   = rsp_line_q;
    assign fill_count = fill_count_q;

endmodule

// File: tb/tb_qspi_fill_arbiter.sv
// Self-checking bench for qspi_fill_arbiter: directed scenarios plus random
// traffic against a round-robin/merge reference model held in the bench.
module tb_qspi_fill_arbiter;

    logic         HCLK;
    logic         HRESETn;
    logic         req0;
    logic [23:0]  addr0;
    logic         ready0;
    logic         rsp_valid0;
    logic         req1;
    logic [23:0]  addr1;
    logic         ready1;
    logic         rsp_valid1;
    logic [127:0] rsp_line;
    logic         fr_rd;
    logic [23:0]  fr_addr;
    logic         fr_done;
    logic [127:0] fr_line;
    logic         busy;
    logic [15:0]  fill_count;

    int tests_run = 0;
    int fails     = 0;

    // Reference model: pending requests per port, round-robin pointer, fill history.
    bit           m_pend [2];
    logic [19:0]  m_paddr [2];
    bit           m_last;
    int           m_count;
    logic [127:0] m_line;

    qspi_fill_arbiter dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .req0       (req0),
        .addr0      (addr0),
        .ready0     (ready0),
        .rsp_valid0 (rsp_valid0),
        .req1       (req1),
        .addr1      (addr1),
        .ready1     (ready1),
        .rsp_valid1 (rsp_valid1),
        .rsp_line   (rsp_line),
        .fr_rd      (fr_rd),
        .fr_addr    (fr_addr),
        .fr_done    (fr_done),
        .fr_line    (fr_line),
        .busy       (busy),
        .fill_count (fill_count)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick;
        @(posedge HCLK);
        #1;
    endtask

    task automatic model_reset;
        m_pend[0] = 1'b0;
        m_pend[1] = 1'b0;
        m_last    = 1'b1;
        m_count   = 0;
        m_line    = '0;
    endtask

    task automatic do_reset;
        req0    = 1'b0;
        req1    = 1'b0;
        fr_done = 1'b0;
        HRESETn = 1'b0;
        tick;
        tick;
        HRESETn = 1'b1;
        model_reset();
    endtask

    // Presents requests for one cycle; the model latches them if it says the port is ready.
    task automatic issue(input bit r0, input logic [23:0] a0, input bit r1, input logic [23:0] a1);
        if (r0) begin
            tests_run++;
            if (ready0 !== 1'b1) begin
                fails++;
                $display("[TB] FAIL ready0_before_req: got %b, required 1", ready0);
            end
        end
        if (r1) begin
            tests_run++;
            if (ready1 !== 1'b1) begin
                fails++;
                $display("[TB] FAIL ready1_before_req: got %b, required 1", ready1);
            end
        end
        req0  = r0;
        addr0 = a0;
        req1  = r1;
        addr1 = a1;
        tick;
        req0 = 1'b0;
        req1 = 1'b0;
        if (r0) begin
            m_pend[0]  = 1'b1;
            m_paddr[0] = a0[23:4];
        end
        if (r1) begin
            m_pend[1]  = 1'b1;
            m_paddr[1] = a1[23:4];
        end
    endtask

    // Plays the flash reader for one fill and checks the arbiter against the model.
    task automatic do_fill(input int dly, input bit inject, input logic [127:0] line,
                           output int wait_cyc, output bit got_port);
        bit          eg;
        bit          em;
        bit          oth;
        bit          seen;
        bit          injected;
        logic [23:0] ea;
        logic [23:0] ia;
        eg       = (m_pend[0] && m_pend[1]) ? ~m_last : m_pend[1];
        em       = m_pend[0] && m_pend[1] && (m_paddr[0] == m_paddr[1]);
        ea       = {m_paddr[eg], 4'h0};
        oth      = ~eg;
        seen     = 1'b0;
        injected = 1'b0;
        wait_cyc = 0;
        got_port = eg;
        for (int i = 0; i < 8; i++) begin
            if (fr_rd === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick;
            wait_cyc++;
        end
        tests_run++;
        if (!seen) begin
            fails++;
            $display("[TB] FAIL fr_rd_timeout: fr_rd=%b after %0d cycles, required 1", fr_rd, wait_cyc);
            return;
        end
        tests_run++;
        if (fr_addr !== ea) begin
            fails++;
            $display("[TB] FAIL fr_addr: got %h, required %h", fr_addr, ea);
        end
        tick;
        tests_run++;
        if (fr_rd !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("[TB] FAIL issue_pulse: fr_rd=%b busy=%b, required fr_rd=0 busy=1", fr_rd, busy);
        end
        for (int i = 0; i < dly; i++) begin
            if (inject && i == 0 && !m_pend[oth]) begin
                ia = ($urandom_range(0, 1) == 0) ? {ea[23:4], 4'($urandom)} : 24'($urandom);
                tests_run++;
                if ((oth ? ready1 : ready0) !== 1'b1) begin
                    fails++;
                    $display("[TB] FAIL ready_other_port: got %b, required 1", oth ? ready1 : ready0);
                end
                if (oth) begin
                    req1  = 1'b1;
                    addr1 = ia;
                end else begin
                    req0  = 1'b1;
                    addr0 = ia;
                end
                injected = 1'b1;
            end
            tick;
            req0 = 1'b0;
            req1 = 1'b0;
            if (injected) begin
                m_pend[oth]  = 1'b1;
                m_paddr[oth] = ia[23:4];
                injected     = 1'b0;
            end
            tests_run++;
            if (rsp_valid0 !== 1'b0 || rsp_valid1 !== 1'b0) begin
                fails++;
                $display("[TB] FAIL early_rsp: rsp_valid0=%b rsp_valid1=%b, required 0 0", rsp_valid0, rsp_valid1);
            end
        end
        fr_line = line;
        fr_done = 1'b1;
        tick;
        fr_done = 1'b0;
        fr_line = {$urandom, $urandom, $urandom, $urandom};
        if (m_count < 65535) m_count++;
        m_line = line;
        tests_run++;
        if (rsp_valid0 !== (!eg || em) || rsp_valid1 !== (eg || em)) begin
            fails++;
            $display("[TB] FAIL rsp_valid: got %b%b, required %b%b", rsp_valid0, rsp_valid1, (!eg || em), (eg || em));
        end
        tests_run++;
        if (rsp_line !== m_line) begin
            fails++;
            $display("[TB] FAIL rsp_line: got %h, required %h", rsp_line, m_line);
        end
        tests_run++;
        if (fill_count !== 16'(m_count)) begin
            fails++;
            $display("[TB] FAIL fill_count: got %0d, required %0d", fill_count, m_count);
        end
        got_port = (rsp_valid1 === 1'b1 && rsp_valid0 !== 1'b1);
        m_pend[eg] = 1'b0;
        if (em) m_pend[oth] = 1'b0;
        m_last = eg;
        tick;
        tests_run++;
        if (rsp_valid0 !== 1'b0 || rsp_valid1 !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL after_resp: rsp_valid=%b%b busy=%b, required 00 0", rsp_valid0, rsp_valid1, busy);
        end
        tests_run++;
        if (ready0 !== !m_pend[0] || ready1 !== !m_pend[1]) begin
            fails++;
            $display("[TB] FAIL ready_after_resp: got %b%b, required %b%b", ready0, ready1, !m_pend[0], !m_pend[1]);
        end
    endtask

    task automatic test_reset;
        do_reset();
        tests_run++;
        if (ready0 !== 1'b1 || ready1 !== 1'b1 || rsp_valid0 !== 1'b0 || rsp_valid1 !== 1'b0 ||
            fr_rd !== 1'b0 || fr_addr !== 24'h0 || rsp_line !== 128'h0 || busy !== 1'b0 || fill_count !== 16'h0) begin
            fails++;
            $display("[TB] FAIL reset_values: rdy=%b%b vld=%b%b rd=%b addr=%h line=%h busy=%b cnt=%0d, required 11 00 0 0 0 0 0",
                     ready0, ready1, rsp_valid0, rsp_valid1, fr_rd, fr_addr, rsp_line, busy, fill_count);
        end
    endtask

    task automatic test_single;
        int w;
        bit p;
        issue(1'b1, 24'h001234, 1'b0, 24'h0);
        tests_run++;
        if (fr_rd !== 1'b0) begin
            fails++;
            $display("[TB] FAIL single_rd_early: fr_rd=%b in cycle T+1, required 0", fr_rd);
        end
        do_fill(19, 1'b0, {16{8'hA5}}, w, p);
        tests_run++;
        if (w != 1) begin
            fails++;
            $display("[TB] FAIL single_rd_latency: fr_rd seen %0d cycles after T+1, required 1", w);
        end
        tests_run++;
        if (p !== 1'b0) begin
            fails++;
            $display("[TB] FAIL single_port: served port %0d, required 0", p);
        end
    endtask

    task automatic test_tie;
        int w;
        bit p;
        do_reset();
        issue(1'b1, 24'h000100, 1'b1, 24'h000200);
        do_fill(5, 1'b0, {$urandom, $urandom, $urandom, $urandom}, w, p);
        tests_run++;
        if (p !== 1'b0) begin
            fails++;
            $display("[TB] FAIL tie_first: served port %0d, required 0", p);
        end
        do_fill(3, 1'b0, {$urandom, $urandom, $urandom, $urandom}, w, p);
        tests_run++;
        if (p !== 1'b1) begin
            fails++;
            $display("[TB] FAIL tie_second: served port %0d, required 1", p);
        end
    endtask

    task automatic test_merge;
        int w;
        bit p;
        int extra_rd;
        issue(1'b1, 24'h000410, 1'b1, 24'h00041C);
        do_fill(4, 1'b0, {$urandom, $urandom, $urandom, $urandom}, w, p);
        extra_rd = 0;
        for (int i = 0; i < 5; i++) begin
            if (fr_rd === 1'b1 || busy === 1'b1) extra_rd++;
            tick;
        end
        tests_run++;
        if (extra_rd != 0) begin
            fails++;
            $display("[TB] FAIL merge_single_read: %0d busy cycles after merged fill, required 0", extra_rd);
        end
    endtask

    task automatic test_fairness;
        int          w;
        bit          p;
        bit          exp_port;
        logic [23:0] a;
        issue(1'b1, 24'h010000, 1'b1, 24'h020000);
        exp_port = ~m_last;
        for (int k = 0; k < 6; k++) begin
            do_fill(int'($urandom_range(0, 4)), 1'b0, {$urandom, $urandom, $urandom, $urandom}, w, p);
            tests_run++;
            if (p !== exp_port) begin
                fails++;
                $display("[TB] FAIL fairness_grant_%0d: served port %0d, required %0d", k, p, exp_port);
            end
            a = {4'h3, 20'($urandom)};
            if (p) issue(1'b0, 24'h0, 1'b1, a);
            else   issue(1'b1, a, 1'b0, 24'h0);
            exp_port = ~exp_port;
        end
        for (int k = 0; k < 4 && (m_pend[0] || m_pend[1]); k++) begin
            do_fill(2, 1'b0, {$urandom, $urandom, $urandom, $urandom}, w, p);
        end
    endtask

    task automatic test_spurious;
        int bad;
        fr_line = ~m_line;
        fr_done = 1'b1;
        tick;
        fr_done = 1'b0;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            if (rsp_valid0 !== 1'b0 || rsp_valid1 !== 1'b0 || busy !== 1'b0) bad++;
            tick;
        end
        tests_run++;
        if (bad != 0) begin
            fails++;
            $display("[TB] FAIL spurious_rsp: %0d cycles with activity, required 0", bad);
        end
        tests_run++;
        if (rsp_line !== m_line || fill_count !== 16'(m_count)) begin
            fails++;
            $display("[TB] FAIL spurious_state: line=%h cnt=%0d, required line=%h cnt=%0d", rsp_line, fill_count, m_line, m_count);
        end
    endtask

    task automatic test_reset_mid;
        int w;
        bit p;
        int bad;
        issue(1'b0, 24'h0, 1'b1, 24'h0ABCD5);
        tick;
        tick;
        tests_run++;
        if (busy !== 1'b1 || ready1 !== 1'b0 || fr_rd !== 1'b0) begin
            fails++;
            $display("[TB] FAIL mid_busy: busy=%b ready1=%b fr_rd=%b, required 1 0 0", busy, ready1, fr_rd);
        end
        #3;
        HRESETn = 1'b0;
        #1;
        tests_run++;
        if (ready0 !== 1'b1 || ready1 !== 1'b1 || busy !== 1'b0 || fr_rd !== 1'b0 || fill_count !== 16'h0 || rsp_line !== 128'h0) begin
            fails++;
            $display("[TB] FAIL mid_reset_values: rdy=%b%b busy=%b rd=%b cnt=%0d, required 11 0 0 0", ready0, ready1, busy, fr_rd, fill_count);
        end
        model_reset();
        tick;
        HRESETn = 1'b1;
        fr_line = {$urandom, $urandom, $urandom, $urandom};
        fr_done = 1'b1;
        tick;
        fr_done = 1'b0;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            if (rsp_valid0 !== 1'b0 || rsp_valid1 !== 1'b0 || busy !== 1'b0) bad++;
            tick;
        end
        tests_run++;
        if (bad != 0 || rsp_line !== 128'h0) begin
            fails++;
            $display("[TB] FAIL late_done: %0d active cycles, line=%h, required 0 and 0", bad, rsp_line);
        end
        issue(1'b0, 24'h0, 1'b1, 24'h0ABCD5);
        do_fill(6, 1'b0, {$urandom, $urandom, $urandom, $urandom}, w, p);
    endtask

    task automatic test_random;
        int          w;
        bit          p;
        int          mode;
        int          guard;
        logic [23:0] a0;
        logic [23:0] a1;
        for (int it = 0; it < 30; it++) begin
            mode = int'($urandom_range(0, 3));
            a0   = 24'($urandom);
            a1   = (mode == 3) ? {a0[23:4], 4'($urandom)} : 24'($urandom);
            issue(mode != 1, a0, mode != 0, a1);
            guard = 0;
            while ((m_pend[0] || m_pend[1]) && guard < 8) begin
                do_fill(int'($urandom_range(0, 6)), ($urandom_range(0, 3) == 0),
                        {$urandom, $urandom, $urandom, $urandom}, w, p);
                guard++;
            end
            if ($urandom_range(0, 1) == 1) tick;
        end
    endtask

    initial begin
        req0    = 1'b0;
        req1    = 1'b0;
        addr0   = '0;
        addr1   = '0;
        fr_done = 1'b0;
        fr_line = '0;
        HRESETn = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_tie();
        test_merge();
        test_fairness();
        test_spurious();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/qspi_fill_arbiter.md
Name: qspi_fill_arbiter

Overview:
Shares one QSPI flash line reader (128-bit line per read, command 0xEB) between two line-fill requesters. Port 0 is the instruction-side XIP cache; port 1 is the data-side / second-master cache. The block latches requests, arbitrates round-robin, and sequences the reader's rd/done handshake. It buffers the returned line and returns it to the winner, plus the loser when both want the same line. It sits between the caches and the flash reader inside the XIP subsystem.

Parameters:
LINE_SIZE, 128, width in bits of one flash line.
ADDR_W, 24, flash byte-address width.
CNT_W, 16, width of the saturating fill counter.

Ports:
HCLK  in  1  clock
HRESETn  in  1  reset; asynchronous, active-low
req0  in  1  port 0 fill request; qualified by ready0
addr0  in  ADDR_W  port 0 byte address; bits [3:0] ignored
ready0  out  1  port 0 can accept a request (no pending request)
rsp_valid0  out  1  one-cycle pulse: rsp_line valid for port 0
req1  in  1  port 1 fill request
addr1  in  ADDR_W  port 1 byte address
ready1  out  1  port 1 can accept a request
rsp_valid1  out  1  one-cycle pulse for port 1
rsp_line  out  LINE_SIZE  registered line buffer, shared by both ports
fr_rd  out  1  one-cycle start pulse to the flash reader
fr_addr  out  ADDR_W  line-aligned address, {addr[ADDR_W-1:4],4'h0}
fr_done  in  1  one-cycle reader completion pulse
fr_line  in  LINE_SIZE  reader data, valid in the fr_done cycle
busy  out  1  high in any state other than IDLE
fill_count  out  CNT_W  completed flash reads, saturating

Behaviour:
- Reset values: ready0=ready1=1; rsp_valid0/1=0; fr_rd=0; fr_addr=0; rsp_line=0; busy=0; fill_count=0; state=IDLE; last_grant=1, so port 0 wins the first tie.
- Acceptance: when reqN && readyN at a rising edge, latch pendN=1 and paddrN=addrN[ADDR_W-1:4]. readyN = ~pendN. reqN while readyN=0 is ignored; the requester holds it.
- FSM states: IDLE, ISSUE, BUSY, RESP.
- IDLE:
  - If exactly one pend is set, grant that port.
  - If both are set, grant ~last_grant.
  - Register gnt, and set merge = pend0 && pend1 && (paddr0==paddr1).
  - Go to ISSUE. If neither pend is set, stay in IDLE.
- ISSUE: fr_rd=1 for exactly this cycle; fr_addr={paddr[gnt],4'h0}, registered and held through BUSY. Go to BUSY.
- BUSY:
  - Wait for fr_done.
  - On fr_done, capture rsp_line<=fr_line, increment fill_count (saturate at all-ones), and go to RESP.
  - fr_done in any other state is ignored and does not change rsp_line.
- RESP:
  - rsp_valid[gnt]=1 and pend[gnt] cleared at the end of the cycle.
  - If merge, rsp_valid[~gnt]=1 and pend[~gnt] cleared as well.
  - last_grant<=gnt. Go to IDLE.
- rsp_line holds its value until the next fr_done, so a requester may sample it at the rsp_valid edge or later.
- Latency: request accepted at edge T; fr_rd high in cycle T+2; fr_done at cycle D; rsp_valid high in cycle D+1. Minimum requester-visible overhead is 3 cycles plus reader time.
- A new request on the port being served:
  - It is accepted only after pend clears, i.e. ready rises in the cycle after RESP.
  - The other port may be accepted at any time.
  - A request accepted after the IDLE arbitration edge is not merged into the current fill.
- Back-to-back: with the other port pending, the next grant goes to it (round-robin). No port waits more than one fill.
- Reset mid-operation: all state and pends are cleared and fr_rd is forced low. Outstanding requests are lost; requesters re-issue after seeing ready high. The flash reader is reset by the same HRESETn.
- Addresses are compared and issued line-aligned only; offsets in addr[3:0] never affect arbitration.

Decomposition:
- Shared package qspi_xip_pkg: FSM state encoding (IDLE=2'd0, ISSUE=2'd1, BUSY=2'd2, RESP=2'd3), LINE_SIZE/ADDR_W defaults, the 0xEB command constant, and the line-offset width (4).
- One natural sub-module, qspi_req_slot: per-port pend/paddr holder with ready output. Instantiate it twice.

Test Plan:
- Single request: req0 with addr0=0x001234 -> fr_rd pulse in cycle T+2 with fr_addr=0x001230; bench drives fr_done 20 cycles later with fr_line=128'hA5…; rsp_valid0 high 1 cycle after done, rsp_line matches, fill_count=1, rsp_valid1 stays 0.
- Tie after reset: req0 (0x000100) and req1 (0x000200) on the same edge -> fill 0x000100 for port 0 first, then 0x000200 for port 1; two fr_rd pulses, two fills.
- Merge: req0=0x000410, req1=0x00041C on the same edge -> one fr_rd with fr_addr=0x000410; rsp_valid0 and rsp_valid1 both high in the same cycle; fill_count increments by 1.
- Fairness: port 0 re-requests immediately after each response while port 1 stays pending -> grants alternate 0,1,0,1; port 1 is never skipped twice.
- Spurious done: fr_done pulsed while in IDLE -> no rsp_valid, rsp_line and fill_count unchanged.
- Reset mid-fill: HRESETn low during BUSY -> ready0/1=1, busy=0, pends cleared; a subsequent late fr_done produces no response; a new request completes normally.
